// File: rtl/arm_pkg.sv
// Shared types and field layout for the arm position playback path.
package arm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitData,
    StHold,
    StPaused,
    StDone
  } arm_state_e;

  localparam int unsigned AXIS_WIDTH = 10;
  localparam int unsigned X_LSB      = 20;
  localparam int unsigned Y_LSB      = 10;
  localparam int unsigned Z_LSB      = 0;

endpackage

// File: rtl/arm_dwell_timer.sv
// Loadable down-counter with freeze; tc flags a count of zero.
module arm_dwell_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/arm_playback_sequencer.sv
// Walks the position memory, presents each X/Y/Z word for a dwell time, and
// pauses while the accelerometer path owns the shared outputs.
module arm_playback_sequencer #(
  parameter int unsigned DATA_WIDTH    = 30,
  parameter int unsigned AXIS_WIDTH    = 10,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned NUM_POSITIONS = 16,
  parameter int unsigned DWELL_CYCLES  = 50_000_000,
  parameter int unsigned RD_TIMEOUT    = 15,
  parameter bit          LOOP_EN       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     select_source,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd_en,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data,
  input  logic                     mem_rd_valid,
  output logic [AXIS_WIDTH-1:0]    x_out,
  output logic [AXIS_WIDTH-1:0]    y_out,
  output logic [AXIS_WIDTH-1:0]    z_out,
  output logic                     pos_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_err
);

  import arm_pkg::*;

  localparam int unsigned MAX_LOAD = (DWELL_CYCLES > RD_TIMEOUT) ? DWELL_CYCLES : RD_TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(MAX_LOAD + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_POSITIONS - 1);

  arm_state_e state_q, state_d, resume_q;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [AXIS_WIDTH-1:0]    x_q, y_q, z_q;
  logic                     pos_valid_q, rd_err_q;

  logic accept_start, latch_data, rd_timeout, advance, pause;
  logic timer_load, timer_en, timer_tc;
  logic [CNT_W-1:0] timer_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    latch_data   = 1'b0;
    rd_timeout   = 1'b0;
    advance      = 1'b0;
    pause        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d      = StFetch;
          accept_start = 1'b1;
        end
      end
      StFetch: begin
        if (stop) begin
          state_d = StIdle;
        end else if (select_source) begin
          state_d = StPaused;
          pause   = 1'b1;
        end else begin
          state_d = StWaitData;
        end
      end
      // select_source is deliberately ignored until the read resolves.
      StWaitData: begin
        if (stop) begin
          state_d = StIdle;
        end else if (mem_rd_valid) begin
          state_d    = StHold;
          latch_data = 1'b1;
        end else if (timer_tc) begin
          state_d    = StIdle;
          rd_timeout = 1'b1;
        end
      end
      StHold: begin
        if (stop) begin
          state_d = StIdle;
        end else if (select_source) begin
          state_d = StPaused;
          pause   = 1'b1;
        end else if (timer_tc) begin
          advance = 1'b1;
          state_d = ((addr_q == LAST_ADDR) && !LOOP_EN) ? StDone : StFetch;
        end
      end
      StPaused: begin
        if (stop) begin
          state_d = StIdle;
        end else if (!select_source) begin
          state_d = resume_q;
        end
      end
      StDone: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start) begin
          state_d      = StFetch;
          accept_start = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // One timer serves both the read timeout and the dwell count.
    timer_load = ((state_q == StFetch) && (state_d == StWaitData)) || latch_data;
    timer_val  = latch_data ? DWELL_LOAD : TIMEOUT_LOAD;
    timer_en   = (state_q == StWaitData) ||
                 ((state_q == StHold) && !select_source && !stop);
  end

  always_comb begin
    busy      = state_q inside {StFetch, StWaitData, StHold, StPaused};
    done      = (state_q == StDone);
    mem_rd_en = (state_q == StFetch) && !stop && !select_source;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      pos_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      resume_q    <= StFetch;
    end else begin
      if (accept_start) begin
        addr_q <= '0;
      end else if (advance && (state_d == StFetch)) begin
        addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      end
      if (pause) begin
        resume_q <= state_q;
      end
      if (latch_data) begin
        x_q <= mem_rd_data[X_LSB +: AXIS_WIDTH];
        y_q <= mem_rd_data[Y_LSB +: AXIS_WIDTH];
        z_q <= mem_rd_data[Z_LSB +: AXIS_WIDTH];
      end
      pos_valid_q <= latch_data;
      if (accept_start) begin
        rd_err_q <= 1'b0;
      end else if (rd_timeout) begin
        rd_err_q <= 1'b1;
      end
    end
  end

  arm_dwell_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .en      (timer_en),
    .tc      (timer_tc)
  );

  assign mem_addr  = addr_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign pos_valid = pos_valid_q;
  assign rd_err    = rd_err_q;

endmodule
